// File: rtl/pio_irq_reader_if.sv
// Avalon-MM style bus between pio_irq_reader (master) and the switch PIO (slave).
interface pio_irq_reader_if;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/pio_irq_reader.sv
// Reads the switch PIO on interrupt, with a holdoff (debounce) after each capture.
// Define PIO_POLL_EN to add a periodic poll that also catches switch releases.
module pio_irq_reader #(
    parameter logic [9:0]  IRQ_MASK       = 10'h3FF,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000,
    parameter logic [23:0] POLL_PERIOD    = 24'd1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     irq,
    pio_irq_reader_if.master         avm,
    output logic [9:0]               sw_value,
    output logic                     sw_valid,
    output logic                     sw_changed,
    output logic [15:0]              event_count
);

    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        RD_REQ,
        RD_WAIT,
        CAPTURE,
        HOLDOFF
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] holdoff_cnt;
    logic [9:0]  capture;
    logic        start_read;

    logic [1:0]  address_q;
    logic        chipselect_q;
    logic        write_n_q;
    logic [31:0] writedata_q;

    logic [21:0] unused_readdata_hi;
    assign unused_readdata_hi = avm.avm_readdata[31:10];

`ifdef PIO_POLL_EN
    logic [23:0] poll_cnt;
    logic        poll_pending;
    logic        poll_expire;

    assign poll_expire = (state != INIT_MASK) && (poll_cnt == 24'd0);

    // An expiry outside IDLE is remembered so a release is never missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt     <= POLL_PERIOD - 24'd1;
            poll_pending <= 1'b0;
        end else begin
            if ((state == RD_REQ) || poll_expire)
                poll_cnt <= POLL_PERIOD - 24'd1;
            else if (state != INIT_MASK)
                poll_cnt <= poll_cnt - 24'd1;

            if (state == RD_REQ)
                poll_pending <= 1'b0;
            else if (poll_expire && (state != IDLE))
                poll_pending <= 1'b1;
        end
    end

    assign start_read = irq || poll_pending || (poll_expire && (state == IDLE));
`else
    logic [23:0] unused_poll_period;
    assign unused_poll_period = POLL_PERIOD;
    assign start_read = irq;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= INIT_MASK;
        else
            state <= state_next;
    end

    // The last holdoff cycle doubles as the IDLE decision, so a held irq re-reads without a gap.
    always_comb begin
        state_next = state;
        case (state)
            INIT_MASK: state_next = IDLE;
            IDLE:      if (start_read) state_next = RD_REQ;
            RD_REQ:    state_next = RD_WAIT;
            RD_WAIT:   state_next = CAPTURE;
            CAPTURE:   state_next = HOLDOFF;
            HOLDOFF:   if (holdoff_cnt == 16'd0) state_next = start_read ? RD_REQ : IDLE;
            default:   state_next = INIT_MASK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            holdoff_cnt <= 16'd0;
        else if (state == CAPTURE)
            holdoff_cnt <= HOLDOFF_CYCLES - 16'd1;
        else if ((state == HOLDOFF) && (holdoff_cnt != 16'd0))
            holdoff_cnt <= holdoff_cnt - 16'd1;
    end

    // Read strobe is registered from the state being entered so it lines up with RD_REQ;
    // the mask write trails INIT_MASK by one cycle because reset holds the bus idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= 2'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= 32'd0;
        end else begin
            address_q    <= 2'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= 32'd0;
            if (state == INIT_MASK) begin
                address_q    <= 2'd2;
                chipselect_q <= 1'b1;
                write_n_q    <= 1'b0;
                writedata_q  <= {22'b0, IRQ_MASK};
            end else if (state_next == RD_REQ) begin
                chipselect_q <= 1'b1;
            end
        end
    end

    assign avm.avm_address    = address_q;
    assign avm.avm_chipselect = chipselect_q;
    assign avm.avm_write_n    = write_n_q;
    assign avm.avm_writedata  = writedata_q;

    // sw_changed is decided at the RD_WAIT sample so it is high exactly during CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture     <= 10'd0;
            sw_value    <= 10'd0;
            sw_valid    <= 1'b0;
            sw_changed  <= 1'b0;
            event_count <= 16'd0;
        end else begin
            sw_changed <= 1'b0;
            if (state == RD_WAIT) begin
                capture    <= avm.avm_readdata[9:0];
                sw_changed <= (avm.avm_readdata[9:0] != sw_value) || !sw_valid;
            end
            if (state == CAPTURE) begin
                sw_value <= capture;
                sw_valid <= 1'b1;
                if (sw_changed)
                    event_count <= event_count + 16'd1;
            end
        end
    end

endmodule
